// File: rtl/riscv_pkg.sv
// Core-wide shared definitions: performance counter width, event count and
// the bit positions of the core event strobes feeding the HPM bank.
package riscv_pkg;

  localparam int PERF_COUNTER_WIDTH = 32;
  localparam int PERF_NUM_EVENTS    = 8;

  typedef enum logic [2:0] {
    EV_CYCLE       = 3'd0,
    EV_RETIRE      = 3'd1,
    EV_BR_TAKEN    = 3'd2,
    EV_BR_MISS     = 3'd3,
    EV_LOAD_USE    = 3'd4,
    EV_DIV_STALL   = 3'd5,
    EV_ICACHE_MISS = 3'd6,
    EV_DCACHE_MISS = 3'd7
  } perf_event_e;

endpackage

// File: rtl/perf_counter_slice.sv
// One HPM counter: event select register, event mux, counter with preload,
// and sticky overflow flag.
module perf_counter_slice #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  freeze,
  input  logic                  inhibit,
  input  logic                  sel_we,
  input  logic [SEL_W-1:0]      sel_data,
  input  logic                  cnt_we,
  input  logic [CNT_WIDTH-1:0]  cnt_data,
  input  logic                  ovf_clr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  ovf
);

  logic [SEL_W-1:0] sel;
  logic             hit;
  logic             inc;

  // Selects above NUM_EVENTS match no strobe and therefore never count.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_EVENTS; k++)
      if (sel == SEL_W'(k + 1)) hit = events[k];
  end

  assign inc = hit & ~inhibit & ~freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (sel_we) sel <= sel_data;
      if (cnt_we)   count <= cnt_data;
      else if (inc) count <= count + 1'b1;
      // A wrap that a preload overrides is not an overflow; set beats clear.
      if (inc && !cnt_we && (&count)) ovf <= 1'b1;
      else if (ovf_clr)               ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of programmable HPM counters with registered read port and overflow irq.
// Optional PERF_SNAPSHOT_EN adds shadow registers captured by snap_i.
module perf_counter_bank
  import riscv_pkg::*;
#(
  parameter int NUM_EVENTS   = PERF_NUM_EVENTS,
  parameter int NUM_COUNTERS = 4,
  parameter int CNT_WIDTH    = PERF_COUNTER_WIDTH,
  parameter int IDX_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1,
  parameter int SEL_W        = $clog2(NUM_EVENTS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_EVENTS-1:0]   events_i,
  input  logic                    freeze_i,
  input  logic [NUM_COUNTERS-1:0] inhibit_i,
  input  logic                    sel_we_i,
  input  logic [IDX_W-1:0]        sel_idx_i,
  input  logic [SEL_W-1:0]        sel_data_i,
  input  logic                    cnt_we_i,
  input  logic [IDX_W-1:0]        cnt_idx_i,
  input  logic [CNT_WIDTH-1:0]    cnt_data_i,
  input  logic                    rd_en_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  input  logic                    rd_shadow_i,
  input  logic                    snap_i,
  output logic [CNT_WIDTH-1:0]    rd_data_o,
  output logic                    rd_valid_o,
  input  logic [NUM_COUNTERS-1:0] ovf_irq_en_i,
  input  logic [NUM_COUNTERS-1:0] ovf_clr_i,
  output logic [NUM_COUNTERS-1:0] ovf_o,
  output logic                    irq_o
);

  logic [NUM_COUNTERS-1:0][CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0]                   live;
  logic [CNT_WIDTH-1:0]                   rd_sel;

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
    perf_counter_slice #(
      .NUM_EVENTS(NUM_EVENTS),
      .CNT_WIDTH (CNT_WIDTH),
      .SEL_W     (SEL_W)
    ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .events  (events_i),
      .freeze  (freeze_i),
      .inhibit (inhibit_i[i]),
      .sel_we  (sel_we_i && (sel_idx_i == IDX_W'(i))),
      .sel_data(sel_data_i),
      .cnt_we  (cnt_we_i && (cnt_idx_i == IDX_W'(i))),
      .cnt_data(cnt_data_i),
      .ovf_clr (ovf_clr_i[i]),
      .count   (count[i]),
      .ovf     (ovf_o[i])
    );
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    live = '0;
    for (int i = 0; i < NUM_COUNTERS; i++)
      if (rd_idx_i == IDX_W'(i)) live = count[i];
  end

`ifdef PERF_SNAPSHOT_EN
  logic [NUM_COUNTERS-1:0][CNT_WIDTH-1:0] shadow;
  logic [CNT_WIDTH-1:0]                   shadow_rd;

  always_ff @(posedge clk) begin
    if (reset)       shadow <= '0;
    else if (snap_i) shadow <= count;
  end

  always_comb begin
    shadow_rd = '0;
    for (int i = 0; i < NUM_COUNTERS; i++)
      if (rd_idx_i == IDX_W'(i)) shadow_rd = shadow[i];
  end

  assign rd_sel = rd_shadow_i ? shadow_rd : live;
`else
  logic unused_snap;
  assign unused_snap = snap_i ^ rd_shadow_i;
  assign rd_sel      = live;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_sel;
      irq_o <= |(ovf_o & ovf_irq_en_i);
    end
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Programmable bank of NUM_COUNTERS hardware performance monitors (HPM), each counting one event selected from a vector of NUM_EVENTS core event strobes.
- Provides per-counter event select, inhibit, software preload, sticky overflow flags with an interrupt output, and a registered read port.
- Sits beside the core pipeline and is driven by retire, branch and stall strobes; the CSR unit uses it as the backing store for mhpmcounter/mhpmevent/mcountinhibit.

Parameters:
- NUM_EVENTS, 8, number of event strobe inputs (1..255).
- NUM_COUNTERS, 4, number of programmable counters (1..32).
- CNT_WIDTH, PERF_COUNTER_WIDTH, counter width in bits (8..64).
- IDX_W, $clog2(NUM_COUNTERS) (minimum 1), counter index width; derived, do not override.
- SEL_W, $clog2(NUM_EVENTS+1), event select width; derived.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- events_i  in  NUM_EVENTS  event strobes; bit k high = one event this cycle
- freeze_i  in  1  global halt of all counting (debug mode)
- inhibit_i  in  NUM_COUNTERS  per-counter count inhibit
- sel_we_i  in  1  write event select
- sel_idx_i  in  IDX_W  counter targeted by sel write
- sel_data_i  in  SEL_W  0 = no event, k = events_i[k-1]
- cnt_we_i  in  1  preload counter value
- cnt_idx_i  in  IDX_W  counter targeted by preload
- cnt_data_i  in  CNT_WIDTH  preload value
- rd_en_i  in  1  read request
- rd_idx_i  in  IDX_W  counter to read
- rd_shadow_i  in  1  read snapshot copy (only with PERF_SNAPSHOT_EN)
- snap_i  in  1  capture all counters (only with PERF_SNAPSHOT_EN)
- rd_data_o  out  CNT_WIDTH  read data
- rd_valid_o  out  1  rd_data_o valid
- ovf_irq_en_i  in  NUM_COUNTERS  per-counter overflow interrupt enable
- ovf_clr_i  in  NUM_COUNTERS  clear sticky overflow flags
- ovf_o  out  NUM_COUNTERS  sticky overflow flags
- irq_o  out  1  |(ovf_o & ovf_irq_en_i), registered

Behaviour:
- Reset: all counters 0, all selects 0, ovf_o 0, irq_o 0, rd_data_o 0, rd_valid_o 0, snapshot registers 0.
- Counting: counter i increments by 1 on a clock edge when sel[i]!=0, events_i[sel[i]-1]=1, inhibit_i[i]=0 and freeze_i=0. At most +1 per cycle per counter.
- Select values greater than NUM_EVENTS are stored as written but count nothing.
- Preload: cnt_we_i writes cnt_data_i to counter cnt_idx_i. A preload beats an increment in the same cycle, so the result is exactly cnt_data_i and no overflow is raised.
- A select write takes effect for counting from the next cycle.
- Out-of-range idx (>= NUM_COUNTERS): writes are ignored; reads return 0 with rd_valid_o=1.
- Overflow: an increment from all-ones wraps the counter to 0 and sets ovf_o[i] on that edge.
- If ovf_clr_i[i] and a new overflow of counter i occur in the same cycle, set wins.
- irq_o updates one cycle after the ovf_o/enable change.
- Read: latency 1. rd_data_o and rd_valid_o are registered; rd_valid_o is high for exactly one cycle per rd_en_i. rd_data_o holds its value while rd_en_i=0.
- Read/write same-cycle ordering: a read of a counter being preloaded or incremented in the same cycle returns the pre-update value.
- Reset asserted mid-operation: all state clears on that edge, and any pending read's rd_valid_o is dropped.

Optional Feature:
- Macro PERF_SNAPSHOT_EN.
- Defined: snap_i copies all counters, with their values before that cycle's update, into shadow registers on one edge. rd_shadow_i=1 makes a read return the shadow value. A snap_i coincident with a read returns the old shadow.
- Undefined: no shadow storage is built; snap_i and rd_shadow_i are ignored and reads always return live counters.

Decomposition:
- riscv_pkg gets:
  - PERF_COUNTER_WIDTH (existing).
  - PERF_NUM_EVENTS.
  - perf_event_e enum for event bit positions: EV_CYCLE=0, EV_RETIRE, EV_BR_TAKEN, EV_BR_MISS, EV_LOAD_USE, EV_DIV_STALL, EV_ICACHE_MISS, EV_DCACHE_MISS.
- Sub-module perf_counter_slice holds one counter, its select register and its overflow flag, and performs the event mux. It is instantiated NUM_COUNTERS times via generate. The top level holds the read mux, the snapshot and irq_o.

Test Plan:
- Reset, then sel[0]=2 (events_i[1]), pulse events_i[1] 5 cycles with a 1-cycle gap -> read idx 0 returns 5, rd_valid_o high exactly one cycle after rd_en_i.
- Preload counter 1 to 2^CNT_WIDTH-2, sel[1]=1, events_i[0] held high 3 cycles -> values FF..FE, FF..FF, 0; ovf_o[1]=1 on the wrap; with ovf_irq_en_i[1]=1, irq_o=1 one cycle later.
- Same cycle: ovf_clr_i[1]=1 and counter 1 wraps again -> ovf_o[1] stays 1. Next cycle clear alone -> 0.
- Counter 2 counting with inhibit_i[2]=1 for 3 cycles, then freeze_i=1 for 2 cycles -> no increments during either window; counter 3 with no inhibit continues counting except during freeze.
- Same cycle: preload counter 0 to 100 with an active event, plus a read of idx 0 -> read returns the old value; the next read returns 100 (not 101); no overflow.
- With PERF_SNAPSHOT_EN: counter 0 at 40, snap_i pulse, 10 further events -> shadow read returns 40, live read returns 50. Without the macro, the same shadow read returns 50.
